// File: rtl/reg_file_sb.sv
// reg_file_sb
//   32 x XLEN integer register file with a busy-bit scoreboard. It sits on the
//   writeback -> decode boundary: writeback data lands here, decode reads two
//   operands combinationally (with same-cycle write bypass), and the scoreboard
//   flags RAW hazards on sources whose producer is still in flight.
//
// Ports
//   clk, rstn                 core clock, asynchronous active-low reset
//   we, rd_addr, rd_data      writeback write port
//   rs1_addr/rs1_data         read port 1 (bypassed)
//   rs2_addr/rs2_data         read port 2 (bypassed)
//   rs1_used, rs2_used        decode actually consumes the source
//   issue_valid, issue_rd     destination leaving decode; marks it busy
//   flush                     cancel all in-flight destinations
//   hazard                    decode must stall
//   dbg_addr/dbg_data         raw array read, no bypass

module reg_file_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            flush,
    output logic            hazard,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            wr_en;

    // x0 is hardwired: writes to it never reach the array or the scoreboard.
    assign wr_en = we && (rd_addr != 5'd0);

    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[rd_addr] = 1'b0;
        // Set is applied after clear so a new producer supersedes the
        // retiring one on the same index; flush overrides both.
        if (flush)
            busy_nxt = '0;
        else if (issue_valid && (issue_rd != 5'd0))
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_en)
                regs[rd_addr] <= rd_data;
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != 5'd0)
            rs1_data = (wr_en && (rd_addr == rs1_addr)) ? rd_data : regs[rs1_addr];
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != 5'd0)
            rs2_data = (wr_en && (rd_addr == rs2_addr)) ? rd_data : regs[rs2_addr];
    end

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

    // A writeback in the same cycle resolves the hazard through the bypass.
    logic busy1_eff;
    logic busy2_eff;

    assign busy1_eff = busy[rs1_addr] && !(wr_en && (rd_addr == rs1_addr));
    assign busy2_eff = busy[rs2_addr] && !(wr_en && (rd_addr == rs2_addr));

    assign hazard = (rs1_used && (rs1_addr != 5'd0) && busy1_eff) ||
                    (rs2_used && (rs2_addr != 5'd0) && busy2_eff);

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 32 x 64-bit integer register file with a busy-bit scoreboard. It is the receiving end of the writeback path.
- Accepts the selected writeback value and destination index, and serves two combinational read ports to decode with same-cycle write bypass.
- Tracks in-flight destination registers so decode can stall on RAW hazards.
- Sits between the writeback select stage and the decode/issue stage of the 64-bit RISC-V core.

Parameters:
- XLEN, 64, data width of each register and of all data ports.
- NREG, 32, number of architectural registers; the index width is log2(NREG) = 5.

Ports:
- clk  input  1  core clock, all state updates on the rising edge
- rstn  input  1  asynchronous active-low reset
- we  input  1  writeback write enable
- rd_addr  input  5  writeback destination index
- rd_data  input  XLEN  writeback value (output of the writeback select stage)
- rs1_addr  input  5  read port 1 index
- rs2_addr  input  5  read port 2 index
- rs1_data  output  XLEN  read port 1 data
- rs2_data  output  XLEN  read port 2 data
- rs1_used  input  1  decode instruction actually reads rs1
- rs2_used  input  1  decode instruction actually reads rs2
- issue_valid  input  1  instruction with a destination leaves decode this cycle
- issue_rd  input  5  destination of the issuing instruction
- flush  input  1  pipeline flush; cancels all in-flight destinations
- hazard  output  1  decode must stall (RAW on a busy source)
- dbg_addr  input  5  debug read index
- dbg_data  output  XLEN  debug read data, raw array contents, no bypass

Behaviour:
Reset (rstn=0, asynchronous):
- All 32 registers are cleared to 0.
- All busy bits are cleared.
- Outputs follow combinationally from the cleared state, so rs1_data=rs2_data=dbg_data=0 and hazard=0.
- Reset asserted mid-operation discards any pending write in that cycle.

Register x0:
- Reads always return 0.
- Writes to index 0 are ignored.
- Busy bit 0 is never set.

Write:
- On the rising clk edge with we=1 and rd_addr!=0, regs[rd_addr] <= rd_data.
- Write latency is 1 cycle into the array.

Read (combinational, zero latency):
- rsN_data = 0 if rsN_addr==0.
- Otherwise rsN_data = rd_data if we=1 and rd_addr==rsN_addr (write-first bypass).
- Otherwise rsN_data = regs[rsN_addr].
- dbg_data = regs[dbg_addr] with no bypass, and 0 for index 0.

Scoreboard (busy[31:1], updated on the rising clk edge):
- Set: issue_valid=1 and issue_rd!=0 sets busy[issue_rd].
- Clear: we=1 and rd_addr!=0 clears busy[rd_addr].
- Simultaneous set and clear on the same index: set wins, because the new producer supersedes the retiring one.
- Set and clear on different indices both take effect in the same cycle.
- flush=1 clears all busy bits. A set in the same cycle as flush is dropped (flush wins). Array writes are not blocked by flush.
- Clearing a bit that is already 0 has no effect.

Hazard (combinational):
- hazard = (rs1_used & rs1_addr!=0 & busy_eff(rs1_addr)) | (rs2_used & rs2_addr!=0 & busy_eff(rs2_addr)).
- busy_eff(i) = busy[i] & ~(we & rd_addr==i), i.e. a same-cycle writeback resolves the hazard through the bypass.
- The instruction under the issue_* ports does not affect hazard in its own cycle. hazard depends only on registered busy bits.
- While hazard=1, decode holds issue_valid low. The block does not gate issue_valid internally.

Width rules:
- All data is exactly XLEN bits.
- No sign extension or truncation is performed.

Test Plan:
1. Reset then read: pulse rstn low, then read rs1_addr=5 and rs2_addr=31 -> rs1_data=rs2_data=0, hazard=0, dbg_data=0.
2. Write and read-back:
   - Write x3=0x0123_4567_89AB_CDEF.
   - Next cycle read rs1_addr=3 -> 0x0123456789ABCDEF.
   - Write x0=0xFFFF_FFFF_FFFF_FFFF, then read rs2_addr=0 -> 0.
3. Bypass:
   - Same cycle: we=1, rd_addr=7, rd_data=0xDEAD_BEEF_0000_0001, rs1_addr=7 -> rs1_data=0xDEADBEEF00000001.
   - dbg_addr=7 still shows the old value (0) until after the edge.
4. RAW stall:
   - Issue issue_rd=10.
   - Next cycle rs1_addr=10, rs1_used=1 -> hazard=1.
   - Same read with rs1_used=0 -> hazard=0.
   - Writeback we=1, rd_addr=10 -> hazard=0 in that cycle, and rs1_data equals rd_data.
5. Set/clear collision and flush:
   - Same edge: issue_rd=12 and writeback rd_addr=12 -> busy[12] remains 1, so hazard=1 on the following read of x12.
   - Then flush=1 with issue_rd=13 -> busy[12] and busy[13] are both 0, so reads of x12 and x13 give hazard=0.
6. Async reset mid-operation:
   - With x4=0x55 and busy[4]=1, assert rstn low between edges.
   - Required: dbg_data for x4 reads 0 immediately, hazard=0, and a we=1 write present during reset is not stored.
